// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
//   pc_state_e : sequencer FSM states (RUN, HALTED, FAULTED)
//   pc_sel_e   : next-PC source select, listed from highest to lowest priority
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    FAULTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_RET  = 3'd0,
    SEL_CALL = 3'd1,
    SEL_JUMP = 3'd2,
    SEL_SKIP = 3'd3,
    SEL_INC  = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder <-> PC sequencer bundle.
//   Controls (decoder drives): en, skip, jump, call, ret, target, halt, resume
//   Status (sequencer drives): address, halted, fault, stack_empty, stack_full
//   modport master : decoder / testbench side
//   modport slave  : pc_sequencer side
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic              en;
  logic              skip;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] address;
  logic              halted;
  logic              fault;
  logic              stack_empty;
  logic              stack_full;

  modport master (
    output en, skip, jump, call, ret, target, halt, resume,
    input  address, halted, fault, stack_empty, stack_full
  );

  modport slave (
    input  en, skip, jump, call, ret, target, halt, resume,
    output address, halted, fault, stack_empty, stack_full
  );

endinterface

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO of return addresses, STACK_DEPTH entries of ADDR_W bits.
//   clk, rst  : clock, synchronous active-high reset (pointer and flags only)
//   i_push    : write i_data on top (caller guarantees not full)
//   i_pop     : discard top entry (caller guarantees not empty)
//   i_data    : address to push
//   o_top     : current top-of-stack entry (undefined while empty)
//   o_empty   : registered, high when no entries
//   o_full    : registered, high when STACK_DEPTH entries held
module pc_ret_stack #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic              r_empty;
  logic              r_full;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  // r_sp points at the next free slot; the top entry sits one below it.
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else if (i_push) begin
      r_sp    <= r_sp + SP_W'(1);
      r_empty <= 1'b0;
      r_full  <= (r_sp == SP_W'(STACK_DEPTH - 1));
    end else if (i_pop) begin
      r_sp    <= r_sp - SP_W'(1);
      r_full  <= 1'b0;
      r_empty <= (r_sp == SP_W'(1));
    end
  end

  assign o_top   = r_mem[w_rd_idx];
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-address logic for the fetch stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_sequencer_if.slave (decoder controls in, PC/status out)
// Next PC by fixed priority ret > call > jump > skip > +1, with halt/resume
// control and a sticky fault on return-stack overflow/underflow.
// Build option: define PC_STACK_EN to include the return-address stack and
// call/ret; without it call acts as jump, ret is ignored, no faults occur.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 5,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  pc_state_e         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic              r_fault;

  pc_sel_e           w_sel;
  logic              w_advance;
  logic              w_fault_req;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_skip;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_top;
  logic              w_empty;
  logic              w_full;

  // halt outranks en, so a request only acts when running and not halting.
  assign w_advance = (r_state == RUN) && !bus.halt && bus.en;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_pc_skip = r_pc + ADDR_W'(2);

  always_comb begin
    w_sel = SEL_INC;
`ifdef PC_STACK_EN
    if (bus.ret)       w_sel = SEL_RET;
    else if (bus.call) w_sel = SEL_CALL;
    else if (bus.jump) w_sel = SEL_JUMP;
    else if (bus.skip) w_sel = SEL_SKIP;
`else
    if (bus.call || bus.jump) w_sel = SEL_JUMP;
    else if (bus.skip)        w_sel = SEL_SKIP;
`endif
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    unique case (w_sel)
      SEL_RET:            w_pc_next = w_top;
      SEL_CALL, SEL_JUMP: w_pc_next = bus.target;
      SEL_SKIP:           w_pc_next = w_pc_skip;
      default:            w_pc_next = w_pc_inc;
    endcase
  end

  assign w_fault_req = w_advance &&
                       (((w_sel == SEL_CALL) && w_full) ||
                        ((w_sel == SEL_RET)  && w_empty));

`ifdef PC_STACK_EN
  logic w_push;
  logic w_pop;

  assign w_push = w_advance && (w_sel == SEL_CALL) && !w_full;
  assign w_pop  = w_advance && (w_sel == SEL_RET)  && !w_empty;

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
`else
  localparam int unsigned unused_stack_depth = STACK_DEPTH;
  logic w_unused_ret;

  assign w_unused_ret = bus.ret;
  assign w_top        = '0;
  assign w_empty      = 1'b1;
  assign w_full       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pc     <= RESET_ADDR;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (w_fault_req) begin
            r_state <= FAULTED;
            r_fault <= 1'b1;
          end else if (bus.en) begin
            r_pc <= w_pc_next;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        FAULTED: begin
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.address     = r_pc;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized control traffic for
// pc_sequencer, compared every cycle against a behavioural model that keeps
// the PC as an integer and the return stack as a queue.
// Honors PC_STACK_EN the same way the design does.
module tb_pc_sequencer;

  localparam int unsigned       ADDR_W  = 5;
  localparam int unsigned       DEPTH   = 4;
  localparam logic [ADDR_W-1:0] RST_A   = '0;
  localparam int                MOD     = 1 << ADDR_W;
`ifdef PC_STACK_EN
  localparam bit                STACK_EN = 1'b1;
`else
  localparam bit                STACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RST_A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  int m_pc;
  bit m_halted;
  bit m_fault;
  int m_stack[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, e, sk, jp, cl, rt, input int tg, input bit hl, rs);
    if (r) begin
      m_pc     = int'(RST_A);
      m_halted = 1'b0;
      m_fault  = 1'b0;
      m_stack.delete();
    end else if (m_fault) begin
      // stuck until reset
    end else if (m_halted) begin
      if (rs) m_halted = 1'b0;
    end else if (hl) begin
      m_halted = 1'b1;
    end else if (e) begin
      if (STACK_EN && rt) begin
        if (m_stack.size() == 0) m_fault = 1'b1;
        else m_pc = m_stack.pop_back();
      end else if (cl) begin
        if (STACK_EN) begin
          if (m_stack.size() == int'(DEPTH)) m_fault = 1'b1;
          else begin
            m_stack.push_back((m_pc + 1) % MOD);
            m_pc = tg % MOD;
          end
        end else begin
          m_pc = tg % MOD;
        end
      end else if (jp) m_pc = tg % MOD;
      else if (sk)     m_pc = (m_pc + 2) % MOD;
      else             m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic step(input bit r, e, sk, jp, cl, rt, input int tg, input bit hl, rs);
    rst        = r;
    ifc.en     = e;
    ifc.skip   = sk;
    ifc.jump   = jp;
    ifc.call   = cl;
    ifc.ret    = rt;
    ifc.target = ADDR_W'(tg);
    ifc.halt   = hl;
    ifc.resume = rs;
    @(posedge clk);
    model_step(r, e, sk, jp, cl, rt, tg, hl, rs);
    #1;
    chk("address",     32'(ifc.address),     32'(m_pc));
    chk("halted",      32'(ifc.halted),      32'(m_halted));
    chk("fault",       32'(ifc.fault),       32'(m_fault));
    chk("stack_empty", 32'(ifc.stack_empty), 32'(m_stack.size() == 0));
    chk("stack_full",  32'(ifc.stack_full),  32'(m_stack.size() == int'(DEPTH)));
  endtask

  task automatic t_rst();          step(1, 0, 0, 0, 0, 0, 0,  0, 0); endtask
  task automatic t_inc();          step(0, 1, 0, 0, 0, 0, 0,  0, 0); endtask
  task automatic t_skip();         step(0, 1, 1, 0, 0, 0, 0,  0, 0); endtask
  task automatic t_jump(input int tg); step(0, 1, 0, 1, 0, 0, tg, 0, 0); endtask
  task automatic t_call(input int tg); step(0, 1, 0, 0, 1, 0, tg, 0, 0); endtask
  task automatic t_ret();          step(0, 1, 0, 0, 0, 1, 0,  0, 0); endtask

  initial begin
    rst = 1'b1;
    ifc.en = 1'b0; ifc.skip = 1'b0; ifc.jump = 1'b0; ifc.call = 1'b0;
    ifc.ret = 1'b0; ifc.target = '0; ifc.halt = 1'b0; ifc.resume = 1'b0;

    // reset, count, wrap-around
    t_rst();
    chk("rst_addr",  32'(ifc.address), 32'(RST_A));
    chk("rst_empty", 32'(ifc.stack_empty), 32'd1);
    t_inc(); t_inc(); t_inc();
    chk("count3", 32'(ifc.address), 32'd3);
    t_jump(30); t_inc(); t_inc();
    chk("wrap_inc", 32'(ifc.address), 32'd0);
    t_jump(31); t_skip();
    chk("wrap_skip", 32'(ifc.address), 32'd1);

    // jump then skip
    t_jump(4); t_jump(12); t_skip();
    chk("jump_skip", 32'(ifc.address), 32'd14);

    // nested call/ret
    t_jump(7); t_call(20); t_call(25); t_ret(); t_ret();
`ifdef PC_STACK_EN
    chk("ret_addr", 32'(ifc.address), 32'd8);
`else
    chk("ret_ignored", 32'(ifc.address), 32'd27);
`endif

    // overflow, ignored ret, reset out of the fault
    t_rst();
    t_call(3); t_call(9); t_call(17); t_call(29); t_call(5); t_ret(); t_inc();
    t_rst();
    chk("post_fault_rst_fault", 32'(ifc.fault), 32'd0);

    // underflow
    t_ret(); t_inc(); t_rst();

    // halt with jump pending, then resume
    t_jump(9);
    step(0, 1, 0, 1, 0, 0, 2, 1, 0);
    step(0, 1, 0, 1, 0, 0, 2, 0, 0);
    step(0, 1, 0, 1, 0, 0, 2, 1, 0);
    step(0, 1, 0, 1, 0, 0, 2, 0, 0);
    chk("halt_hold", 32'(ifc.address), 32'd9);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1);
    t_inc();
    chk("resume_adv", 32'(ifc.address), 32'd10);

    // halt outranks a stalled en
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

`ifndef PC_STACK_EN
    t_call(6);
    chk("nostack_call", 32'(ifc.address), 32'd6);
    chk("nostack_empty", 32'(ifc.stack_empty), 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit r, e, sk, jp, cl, rt, hl, rs;
      int tg;
      r  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 85);
      sk = ($urandom_range(0, 99) < 25);
      jp = ($urandom_range(0, 99) < 10);
      cl = ($urandom_range(0, 99) < 15);
      rt = ($urandom_range(0, 99) < 15);
      hl = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 99) < 30);
      tg = int'($urandom_range(0, MOD - 1));
      step(r, e, sk, jp, cl, rt, tg, hl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
